// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline has priority, and long-latency
// results wait in a small FIFO. Starvation, full-FIFO and same-register (WAW) checks force FIFO drains.
module wb_port_arbiter #(
  parameter int REG_WIDTH    = 32,
  parameter int IDX_WIDTH    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic                        I_PipeValid,
  input  logic [IDX_WIDTH-1:0]        I_PipeRegIdx,
  input  logic [REG_WIDTH-1:0]        I_PipeData,
  output logic                        O_PipeStall,
  input  logic                        I_LLValid,
  input  logic [IDX_WIDTH-1:0]        I_LLRegIdx,
  input  logic [REG_WIDTH-1:0]        I_LLData,
  output logic                        O_LLReady,
  output logic                        O_WriteBackEnable,
  output logic [IDX_WIDTH-1:0]        O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]        O_WriteBackData,
  output logic [(1<<IDX_WIDTH)-1:0]   O_PendingMask,
  output logic [$clog2(FIFO_DEPTH):0] O_FifoCount
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {S_PIPE, S_DRAIN} stateT;

  logic [IDX_WIDTH-1:0]  fifoIdx  [FIFO_DEPTH];
  logic [REG_WIDTH-1:0]  fifoData [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifoValid;
  logic [PTR_W-1:0]      wrPtr, rdPtr;
  logic [CNT_W-1:0]      count, countNext;
  logic [SW-1:0]         starveCnt, starveNext;
  stateT                 state;

  logic                  wbEn_p1, wbFromFifo_p1;
  logic [IDX_WIDTH-1:0]  wbIdx_p1;
  logic [REG_WIDTH-1:0]  wbData_p1;

  logic fifoEmpty, fifoFull, llReady, push, wawHit, grantPipe, grantFifo;

  // p0: combinational arbitration on this cycle's requests
  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == DEPTH_C);
  assign llReady   = I_LOCK & ~I_RESET & ~fifoFull;
  assign push      = I_LLValid & llReady;

  always_comb begin
    wawHit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (fifoValid[i] && (fifoIdx[i] == I_PipeRegIdx)) wawHit = 1'b1;
    wawHit = wawHit & I_PipeValid;
  end

  // An older queued write to the same register must retire before the pipeline's.
  always_comb begin
    grantPipe = 1'b0;
    grantFifo = 1'b0;
    if (I_LOCK && !I_RESET) begin
      if (state == S_DRAIN || wawHit) grantFifo = ~fifoEmpty;
      else if (I_PipeValid)           grantPipe = 1'b1;
      else                            grantFifo = ~fifoEmpty;
    end
  end

  always_comb begin
    countNext = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, grantFifo};
    starveNext = starveCnt;
    if (I_LOCK) begin
      if (grantFifo || fifoEmpty) starveNext = '0;
      else if (grantPipe && starveCnt != STARVE_MAX) starveNext = starveCnt + 1'b1;
    end
  end

  // p0 -> p1: FIFO, FSM and write-port output register
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      fifoValid     <= '0;
      wrPtr         <= '0;
      rdPtr         <= '0;
      count         <= '0;
      starveCnt     <= '0;
      state         <= S_PIPE;
      wbEn_p1       <= 1'b0;
      wbFromFifo_p1 <= 1'b0;
      wbIdx_p1      <= '0;
      wbData_p1     <= '0;
    end else begin
      if (grantFifo) begin
        fifoValid[rdPtr] <= 1'b0;
        rdPtr            <= rdPtr + 1'b1;
      end
      if (push) begin
        fifoValid[wrPtr] <= 1'b1;
        wrPtr            <= wrPtr + 1'b1;
      end
      count     <= countNext;
      starveCnt <= starveNext;
      if (I_LOCK) begin
        if (state == S_PIPE) begin
          if (starveNext == STARVE_MAX || (fifoFull && I_PipeValid)) state <= S_DRAIN;
        end else if (grantFifo || fifoEmpty) begin
          state <= (countNext == DEPTH_C) ? S_DRAIN : S_PIPE;
        end
      end
      if (grantPipe) begin
        wbEn_p1       <= 1'b1;
        wbFromFifo_p1 <= 1'b0;
        wbIdx_p1      <= I_PipeRegIdx;
        wbData_p1     <= I_PipeData;
      end else if (grantFifo) begin
        wbEn_p1       <= 1'b1;
        wbFromFifo_p1 <= 1'b1;
        wbIdx_p1      <= fifoIdx[rdPtr];
        wbData_p1     <= fifoData[rdPtr];
      end else begin
        wbEn_p1       <= 1'b0;
        wbFromFifo_p1 <= 1'b0;
        wbIdx_p1      <= '0;
        wbData_p1     <= '0;
      end
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (push) begin
      fifoIdx[wrPtr]  <= I_LLRegIdx;
      fifoData[wrPtr] <= I_LLData;
    end
  end

  // p1: registered write port and dependence mask for decode
  always_comb begin
    O_PendingMask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (fifoValid[i]) O_PendingMask[fifoIdx[i]] = 1'b1;
    if (wbEn_p1 && wbFromFifo_p1) O_PendingMask[wbIdx_p1] = 1'b1;
  end

  assign O_PipeStall       = I_PipeValid & I_LOCK & ~I_RESET & ~grantPipe;
  assign O_LLReady         = llReady;
  assign O_WriteBackEnable = wbEn_p1;
  assign O_WriteBackRegIdx = wbIdx_p1;
  assign O_WriteBackData   = wbData_p1;
  assign O_FifoCount       = count;
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline writeback path and a long-latency result unit (multi-cycle loads/multiply). Long-latency results are queued in a small FIFO, and pipeline results take priority. A starvation counter and a full-FIFO check force drain slots, and a WAW check keeps same-register writes in program order. The block sits between the writeback stage and the decode-stage register file, and exports a pending-register mask that decode uses for dependence stalls.

## Interface
- REG_WIDTH, 32, data width of a register write
- IDX_WIDTH, 4, register index width (16 architectural registers)
- FIFO_DEPTH, 4, long-latency queue entries; power of 2, ≥2
- STARVE_LIMIT, 3, consecutive pipeline wins allowed while FIFO non-empty before a forced drain slot
- I_CLOCK  in  1  clock, all state on rising edge
- I_RESET  in  1  asynchronous, active-high reset
- I_LOCK  in  1  run enable; 0 = hold all state, no grants, no pushes
- I_PipeValid  in  1  pipeline write request
- I_PipeRegIdx  in  IDX_WIDTH  pipeline destination register
- I_PipeData  in  REG_WIDTH  pipeline write data
- O_PipeStall  out  1  pipeline request not granted this cycle; pipeline holds its request
- I_LLValid  in  1  long-latency result valid
- I_LLRegIdx  in  IDX_WIDTH  long-latency destination register
- I_LLData  in  REG_WIDTH  long-latency result data
- O_LLReady  out  1  FIFO can accept; push occurs when I_LLValid & O_LLReady
- O_WriteBackEnable  out  1  register file write enable (registered)
- O_WriteBackRegIdx  out  IDX_WIDTH  register file write index (registered)
- O_WriteBackData  out  REG_WIDTH  register file write data (registered)
- O_PendingMask  out  2^IDX_WIDTH  bit r set if register r has a queued or in-flight long-latency write
- O_FifoCount  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FIFO storage: circular buffer holding {idx, data}, with read/write pointers that wrap at FIFO_DEPTH and a separate count.
- Long-latency results always pass through the FIFO. There is no bypass, so a result pushed in cycle N can pop in cycle N+1 at the earliest.
- O_LLReady = I_LOCK & ~I_RESET & (count < FIFO_DEPTH). It does not take credit for a same-cycle pop.
- FSM states:
  - S_PIPE (reset state): the pipeline wins when I_PipeValid=1. Otherwise the FIFO head wins if the FIFO is non-empty.
  - S_DRAIN: the FIFO head wins unconditionally. O_PipeStall = I_PipeValid.
- Transitions:
  - S_PIPE→S_DRAIN when the starve counter == STARVE_LIMIT, or when count == FIFO_DEPTH while I_PipeValid=1.
  - S_DRAIN→S_PIPE after one pop, unless the FIFO is still full. If still full, remain in S_DRAIN.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when the pipeline is granted and the FIFO is non-empty.
  - Clears on any pop or whenever the FIFO is empty.
- WAW ordering: if I_PipeValid and I_PipeRegIdx matches any valid FIFO entry, the FIFO head is granted and O_PipeStall=1. This repeats every cycle until no match remains, in any state.
- Grant effect:
  - Pipeline grant loads {1, I_PipeRegIdx, I_PipeData} into the output register.
  - FIFO grant loads the head entry and pops it.
  - No grant loads O_WriteBackEnable=0; index and data are then don't-care but driven 0.
- O_PendingMask = OR of one-hot(idx) over valid FIFO entries, plus one-hot(O_WriteBackRegIdx) when the output register holds a FIFO-sourced entry.
- I_LOCK=0:
  - No push, pop or grant; O_PipeStall=0.
  - The output register loads enable=0 at the next edge.
  - FSM, counter and FIFO contents are held.

## Timing
- Arbitration is combinational on cycle-N inputs; the write port shows the winner in cycle N+1 (1-cycle latency).
- O_PipeStall is combinational in cycle N. A stalled pipeline request must be held unchanged until a cycle with O_PipeStall=0.
- Simultaneous push and pop with the FIFO not full: count unchanged; both pointers advance.
- Push when FIFO empty and pipeline idle: pop and write occur the next cycle, so O_WriteBackEnable is seen at N+2 after the push cycle.
- Reset (asynchronous, any cycle, including mid-drain):
  - All FIFO entries are invalidated; count=0; pointers=0; state S_PIPE; starve counter 0.
  - O_WriteBackEnable=0, O_WriteBackRegIdx=0, O_WriteBackData=0.
  - O_PendingMask=0, O_FifoCount=0, O_PipeStall=0, O_LLReady=0.
  - Pending queued writes are discarded.
- The first grant is possible in the first cycle after I_RESET deasserts with I_LOCK=1.

## Test plan
- Pipeline-only stream of ADDs to r1..r5 with LL idle → write port shows r1..r5 one cycle after each request, no stalls, O_PendingMask=0.
- LL push r7=0xDEAD with pipeline idle → O_PendingMask bit 7 is set the next cycle, write r7=0xDEAD two cycles after the push, and the mask clears after the write retires.
- LL push r9, then continuous pipeline requests to r1..r6 with STARVE_LIMIT=3 → three pipeline writes, then O_PipeStall=1 for one cycle and r9 is written, after which pipeline writes resume.
- FIFO filled to 4 entries with the pipeline busy → O_LLReady=0, FSM enters S_DRAIN, the FIFO drains until not full, and a fifth LL valid is held off without loss.
- LL queued r3=0x11, then pipeline request r3=0x22 → pipeline stalls, the write order is r3=0x11 then r3=0x22, and the final register value is 0x22.
- Assert I_RESET mid-drain with 3 entries queued → all outputs go to 0 immediately and count=0, and no queued write appears after reset release.
